bf_fetch_unit: RTL and testbench

- Instruction fetch and sequencing stage for the brainfuck CPU. Sits directly downstream of the program ROM.
- Owns the program counter. Drives the ROM address and consumes the 3-bit opcode and overrun flag.
- Resolves `[` and `]` locally using a hardware loop stack and a forward-skip scanner.
- Issues only data ops (+ - > < . ,) to the execute stage over a valid/ready handshake.

---
 rtl/bf_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_bf_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bf_fetch_unit.sv
// rtl/bf_fetch_unit.sv - brainfuck fetch/sequencing stage with loop stack and skip scanner
module bf_fetch_unit #(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_code,
    input  logic              rom_overrun,
    output logic              op_valid,
    output logic [2:0]        op_code,
    input  logic              op_ready,
    input  logic              exec_idle,
    input  logic              cell_zero,
    output logic              running,
    output logic              halted,
    output logic              error,
    output logic [1:0]        err_code
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0]   SP_FULL   = SP_W'(STACK_DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SKIP, S_HALT, S_ERROR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [SP_W-1:0]   sp, sp_nxt;
    logic [ADDR_W:0]   depth, depth_nxt;
    logic [1:0]        err_r, err_nxt;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [ADDR_W-1:0] top;
    logic              push, adv;
    logic              is_open, is_close;

    assign is_open  = (rom_code == 3'b011);
    assign is_close = (rom_code == 3'b010);
    assign top      = (sp == '0) ? '0 : stack[IDX_W'(sp - 1'b1)];

    assign rom_addr = pc;
    assign op_code  = rom_code;
    assign op_valid = (state == S_RUN) && !rom_overrun && !is_open && !is_close;
    assign running  = (state == S_RUN) || (state == S_SKIP);
    assign halted   = (state == S_HALT);
    assign error    = (state == S_ERROR);
    assign err_code = err_r;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sp_nxt    = sp;
        depth_nxt = depth;
        err_nxt   = err_r;
        push      = 1'b0;
        adv       = 1'b0;
        case (state)
            S_RUN: begin
                if (rom_overrun) begin
                    state_nxt = S_HALT;
                end else if (is_open) begin
                    if (exec_idle) begin
                        if (cell_zero) begin
                            depth_nxt = DEPTH_ONE;
                            state_nxt = S_SKIP;
                            adv       = 1'b1;
                        end else if (sp == SP_FULL) begin
                            state_nxt = S_ERROR;
                            err_nxt   = 2'd1;
                        end else begin
                            push   = 1'b1;
                            sp_nxt = sp + 1'b1;
                            adv    = 1'b1;
                        end
                    end
                end else if (is_close) begin
                    if (exec_idle) begin
                        if (sp == '0) begin
                            state_nxt = S_ERROR;
                            err_nxt   = 2'd2;
                        end else if (!cell_zero) begin
                            pc_nxt = top + 1'b1;
                        end else begin
                            sp_nxt = sp - 1'b1;
                            adv    = 1'b1;
                        end
                    end
                end else if (op_ready) begin
                    adv = 1'b1;
                end
            end
            S_SKIP: begin
                if (rom_overrun) begin
                    state_nxt = S_ERROR;
                    err_nxt   = 2'd3;
                end else begin
                    if (is_open) begin
                        depth_nxt = depth + 1'b1;
                    end else if (is_close) begin
                        depth_nxt = depth - 1'b1;
                        if (depth == DEPTH_ONE) state_nxt = S_RUN;
                    end
                    adv = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    pc_nxt    = '0;
                    sp_nxt    = '0;
                    depth_nxt = '0;
                    err_nxt   = 2'd0;
                    state_nxt = S_RUN;
                end
            end
        endcase
        // Stepping past the last addressable word ends the program.
        if (adv) begin
            if (&pc) state_nxt = S_HALT;
            else     pc_nxt    = pc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            sp    <= '0;
            depth <= '0;
            err_r <= 2'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            sp    <= sp_nxt;
            depth <= depth_nxt;
            err_r <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) stack[IDX_W'(sp)] <= pc;
    end
endmodule

// File: tb/tb_bf_fetch_unit.sv
// tb/tb_bf_fetch_unit.sv - scoreboard bench for bf_fetch_unit
module tb_bf_fetch_unit;
    localparam int ADDR_W      = 10;
    localparam int STACK_DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst, start, op_ready, exec_idle, cell_zero;
    logic [ADDR_W-1:0] rom_addr;
    logic [2:0]        rom_code;
    logic              rom_overrun;
    logic              op_valid;
    logic [2:0]        op_code;
    logic              running, halted, error;
    logic [1:0]        err_code;

    logic [2:0] rom [0:1023];
    int         prog_len;
    logic [2:0] exp_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;
    int         cyc;

    assign rom_code    = rom[rom_addr];
    assign rom_overrun = (int'(rom_addr) >= prog_len);

    bf_fetch_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_code(rom_code), .rom_overrun(rom_overrun),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
        .exec_idle(exec_idle), .cell_zero(cell_zero),
        .running(running), .halted(halted), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && op_valid && op_ready) begin
            if (exp_q.size() == 0) check("op_unexpected", exp_q.size(), 1);
            else check("op_code", {29'b0, op_code}, {29'b0, exp_q.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 3'b001;
    endtask

    task automatic wait_end(input int limit, output int n);
        n = 0;
        while (!(halted || error) && n < limit) begin
            step();
            n++;
        end
        if (!(halted || error)) check("end_timeout", n, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_ready = 1'b1; exec_idle = 1'b1; cell_zero = 1'b0;
        clear_rom();
        prog_len = 0;
        step(); step();
        rst = 1'b0;
        check("rst_op_valid", op_valid, 0);
        check("rst_running", running, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        check("rst_addr", rom_addr, 0);

        // + + . then overrun
        clear_rom();
        rom[0] = 3'b111; rom[1] = 3'b111; rom[2] = 3'b001; prog_len = 3;
        exp_q.push_back(3'b111); exp_q.push_back(3'b111); exp_q.push_back(3'b001);
        pulse_start();
        wait_end(50, cyc);
        check("t1_halt_cycle", cyc, 4);
        check("t1_halted", halted, 1);
        check("t1_drain", exp_q.size(), 0);

        // backpressure on >
        clear_rom();
        rom[0] = 3'b101; prog_len = 1;
        op_ready = 1'b0;
        exp_q.push_back(3'b101);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("t2_valid", op_valid, 1);
            check("t2_addr", rom_addr, 0);
            check("t2_code", op_code, 3'b101);
            step();
        end
        op_ready = 1'b1;
        step();
        check("t2_adv", rom_addr, 1);
        wait_end(20, cyc);
        check("t2_halted", halted, 1);
        check("t2_drain", exp_q.size(), 0);

        // [ at 0x38 stalled by exec_idle, then loop back via ]
        clear_rom();
        for (int i = 0; i < 'h38; i++) begin
            rom[i] = 3'b111;
            exp_q.push_back(3'b111);
        end
        rom['h38] = 3'b011; rom['h39] = 3'b110; rom['h3a] = 3'b010; prog_len = 'h3b;
        exp_q.push_back(3'b110); exp_q.push_back(3'b110);
        exec_idle = 1'b0; cell_zero = 1'b0;
        pulse_start();
        for (int i = 0; i < 200 && rom_addr != 10'h38; i++) step();
        check("t3_reach", rom_addr, 'h38);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_stall_addr", rom_addr, 'h38);
            check("t3_stall_valid", op_valid, 0);
        end
        exec_idle = 1'b1;
        step();
        check("t3_push_adv", rom_addr, 'h39);
        step();
        check("t3_close", rom_addr, 'h3a);
        step();
        check("t3_loopback", rom_addr, 'h39);
        cell_zero = 1'b1;
        step(); step();
        check("t3_pop_adv", rom_addr, 'h3b);
        wait_end(20, cyc);
        check("t3_halted", halted, 1);
        check("t3_drain", exp_q.size(), 0);

        // [ [ - ] + ] . with cell_zero at the first [
        clear_rom();
        rom[0] = 3'b011; rom[1] = 3'b011; rom[2] = 3'b110; rom[3] = 3'b010;
        rom[4] = 3'b111; rom[5] = 3'b010; rom[6] = 3'b001; prog_len = 7;
        exp_q.push_back(3'b001);
        cell_zero = 1'b1;
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            step();
            check("t4_skip_addr", rom_addr, i);
            check("t4_running", running, 1);
        end
        check("t4_resume_valid", op_valid, 1);
        wait_end(20, cyc);
        check("t4_halted", halted, 1);
        check("t4_drain", exp_q.size(), 0);

        // stack overflow on the 17th nested [
        clear_rom();
        for (int i = 0; i <= STACK_DEPTH; i++) rom[i] = 3'b011;
        prog_len = 100;
        cell_zero = 1'b0;
        pulse_start();
        wait_end(100, cyc);
        check("t5_err", error, 1);
        check("t5_code1", err_code, 1);
        check("t5_frozen_pc", rom_addr, STACK_DEPTH);
        check("t5_not_running", running, 0);

        // unmatched ] restarted from ERROR
        clear_rom();
        rom[0] = 3'b010; prog_len = 5;
        pulse_start();
        check("t5b_restart_addr", rom_addr, 0);
        check("t5b_cleared", err_code, 0);
        wait_end(20, cyc);
        check("t5b_code2", err_code, 2);

        // unterminated skip
        clear_rom();
        rom[0] = 3'b011; rom[1] = 3'b111; rom[2] = 3'b111; prog_len = 3;
        cell_zero = 1'b1;
        pulse_start();
        wait_end(20, cyc);
        check("t5c_code3", err_code, 3);
        check("t5c_addr", rom_addr, 3);

        // rst in the middle of SKIP, then restart with a fresh stack
        clear_rom();
        rom[0] = 3'b011; rom[1] = 3'b011;
        for (int i = 2; i < 8; i++) rom[i] = 3'b111;
        prog_len = 8;
        cell_zero = 1'b0;
        pulse_start();
        step();
        cell_zero = 1'b1;
        step(); step();
        check("t6_in_skip", running, 1);
        check("t6_skip_addr", rom_addr, 3);
        rst = 1'b1;
        step();
        check("t6_rst_addr", rom_addr, 0);
        check("t6_rst_running", running, 0);
        check("t6_rst_valid", op_valid, 0);
        check("t6_rst_error", error, 0);
        rst = 1'b0;
        rom[0] = 3'b010; prog_len = 1;
        cell_zero = 1'b0;
        pulse_start();
        check("t6_restart_addr", rom_addr, 0);
        wait_end(20, cyc);
        check("t6_empty_stack", err_code, 2);
        check("t6_final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
